// File: rtl/trdb_priority_pkt.sv
// Trace-encoder packet priority unit: branch map, last-cycle flags and resync
// counter, with a one-entry valid/ready output register.
module trdb_priority_pkt #(
  parameter int unsigned          BRANCH_MAP_LEN = 31,
  parameter int unsigned          RESYNC_W       = 16,
  parameter logic [RESYNC_W-1:0]  RESYNC_MAX     = RESYNC_W'(1024),
  parameter int unsigned          RESYNC_MODE    = 0,
  localparam int unsigned         CNT_W          = $clog2(BRANCH_MAP_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      retired_i,
  input  logic                      branch_i,
  input  logic                      branch_taken_i,
  input  logic                      exception_i,
  input  logic                      updiscon_i,
  input  logic                      first_qualified_i,
  input  logic                      privchange_i,
  input  logic                      context_change_i,
  input  logic                      enc_disabled_i,
  input  logic                      opmode_change_i,
  output logic                      packet_valid_o,
  input  logic                      packet_ready_i,
  output logic [1:0]                packet_format_o,
  output logic [1:0]                packet_subformat_o,
  output logic                      thaddr_o,
  output logic [BRANCH_MAP_LEN-1:0] branch_map_o,
  output logic [CNT_W-1:0]          branch_cnt_o,
  output logic                      resync_pend_o
);

  localparam logic [1:0] FMT_F1     = 2'd1;
  localparam logic [1:0] FMT_F2     = 2'd2;
  localparam logic [1:0] FMT_F3     = 2'd3;
  localparam logic [1:0] SF_START   = 2'd0;
  localparam logic [1:0] SF_TRAP    = 2'd1;
  localparam logic [1:0] SF_CONTEXT = 2'd2;
  localparam logic [1:0] SF_SUPPORT = 2'd3;

  // Stored context
  logic [BRANCH_MAP_LEN-1:0] map_q, map_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      lc_exception_q, lc_exception_d;
  logic                      lc_updiscon_q, lc_updiscon_d;
  logic [RESYNC_W-1:0]       resync_cnt_q, resync_cnt_d;
  logic                      resync_pend_q, resync_pend_d;

  // Output register
  logic                      pkt_valid_q, pkt_valid_d;
  logic [1:0]                fmt_q, fmt_d;
  logic [1:0]                sf_q, sf_d;
  logic                      thaddr_q, thaddr_d;
  logic [BRANCH_MAP_LEN-1:0] out_map_q, out_map_d;
  logic [CNT_W-1:0]          out_cnt_q, out_cnt_d;

  logic                      accept_c;
  logic [BRANCH_MAP_LEN-1:0] map_upd_c;
  logic [CNT_W-1:0]          cnt_upd_c;
  logic                      emit_c;
  logic [1:0]                fmt_c;
  logic [1:0]                sf_c;
  logic                      thaddr_c;

  assign ready_o  = !pkt_valid_q || packet_ready_i;
  assign accept_c = valid_i && ready_o;

  // Map including this beat's branch; the packet decision sees this view
  always_comb begin
    map_upd_c = map_q;
    cnt_upd_c = cnt_q;
    if (retired_i && branch_i) begin
      for (int unsigned k = 0; k < BRANCH_MAP_LEN; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          map_upd_c[k] = branch_taken_i;
        end
      end
      cnt_upd_c = cnt_q + CNT_W'(1);
    end
  end

  // Priority decision, first match wins
  always_comb begin
    emit_c   = 1'b1;
    fmt_c    = 2'd0;
    sf_c     = 2'd0;
    thaddr_c = 1'b0;
    if (lc_exception_q) begin
      fmt_c    = FMT_F3;
      sf_c     = SF_TRAP;
      thaddr_c = 1'b1;
    end else if (first_qualified_i || privchange_i ||
                 (resync_pend_q && (cnt_upd_c == '0))) begin
      fmt_c = FMT_F3;
      sf_c  = SF_START;
    end else if (context_change_i) begin
      fmt_c = FMT_F3;
      sf_c  = SF_CONTEXT;
    end else if (enc_disabled_i || opmode_change_i) begin
      fmt_c = FMT_F3;
      sf_c  = SF_SUPPORT;
    end else if (lc_updiscon_q || resync_pend_q) begin
      fmt_c = (cnt_upd_c == '0) ? FMT_F2 : FMT_F1;
    end else if (cnt_upd_c == CNT_W'(BRANCH_MAP_LEN)) begin
      fmt_c = FMT_F1;
    end else begin
      emit_c = 1'b0;
    end
  end

  // Next-state for context and output register
  always_comb begin
    map_d          = map_q;
    cnt_d          = cnt_q;
    lc_exception_d = lc_exception_q;
    lc_updiscon_d  = lc_updiscon_q;
    resync_cnt_d   = resync_cnt_q;
    pkt_valid_d    = pkt_valid_q;
    fmt_d          = fmt_q;
    sf_d           = sf_q;
    thaddr_d       = thaddr_q;
    out_map_d      = out_map_q;
    out_cnt_d      = out_cnt_q;

    if (pkt_valid_q && packet_ready_i) begin
      pkt_valid_d = 1'b0;
    end

    if (accept_c) begin
      lc_exception_d = exception_i;
      lc_updiscon_d  = updiscon_i;
      pkt_valid_d    = emit_c;
      fmt_d          = fmt_c;
      sf_d           = sf_c;
      thaddr_d       = thaddr_c;
      out_map_d      = '0;
      out_cnt_d      = '0;
      if (emit_c && (fmt_c != FMT_F2)) begin
        out_map_d = map_upd_c;
        out_cnt_d = cnt_upd_c;
      end
      if (emit_c) begin
        map_d = '0;
        cnt_d = '0;
      end else begin
        map_d = map_upd_c;
        cnt_d = cnt_upd_c;
      end
      // F3 restarts the resync interval and overrides any increment
      if (emit_c && (fmt_c == FMT_F3)) begin
        resync_cnt_d = '0;
      end else if ((((RESYNC_MODE == 0) && retired_i) ||
                    ((RESYNC_MODE != 0) && emit_c)) &&
                   (resync_cnt_q != '1)) begin
        resync_cnt_d = resync_cnt_q + RESYNC_W'(1);
      end
    end

    resync_pend_d = (resync_cnt_d > RESYNC_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      map_q          <= '0;
      cnt_q          <= '0;
      lc_exception_q <= 1'b0;
      lc_updiscon_q  <= 1'b0;
      resync_cnt_q   <= '0;
      resync_pend_q  <= 1'b0;
      pkt_valid_q    <= 1'b0;
      fmt_q          <= '0;
      sf_q           <= '0;
      thaddr_q       <= 1'b0;
      out_map_q      <= '0;
      out_cnt_q      <= '0;
    end else begin
      map_q          <= map_d;
      cnt_q          <= cnt_d;
      lc_exception_q <= lc_exception_d;
      lc_updiscon_q  <= lc_updiscon_d;
      resync_cnt_q   <= resync_cnt_d;
      resync_pend_q  <= resync_pend_d;
      pkt_valid_q    <= pkt_valid_d;
      fmt_q          <= fmt_d;
      sf_q           <= sf_d;
      thaddr_q       <= thaddr_d;
      out_map_q      <= out_map_d;
      out_cnt_q      <= out_cnt_d;
    end
  end

  assign packet_valid_o     = pkt_valid_q;
  assign packet_format_o    = fmt_q;
  assign packet_subformat_o = sf_q;
  assign thaddr_o           = thaddr_q;
  assign branch_map_o       = out_map_q;
  assign branch_cnt_o       = out_cnt_q;
  assign resync_pend_o      = resync_pend_q;

endmodule

// File: tb/tb_trdb_priority_pkt.sv
// Scoreboard bench for trdb_priority_pkt: directed scenarios plus random beats
// against a queue-based reference model.
module tb_trdb_priority_pkt;

  localparam int unsigned LEN  = 31;
  localparam int unsigned RW   = 16;
  localparam int unsigned RMAX = 40;
  localparam int unsigned CW   = $clog2(LEN + 1);

  localparam logic [9:0] B_RET   = 10'd1;
  localparam logic [9:0] B_BR    = 10'd2;
  localparam logic [9:0] B_TK    = 10'd4;
  localparam logic [9:0] B_EXC   = 10'd8;
  localparam logic [9:0] B_UPD   = 10'd16;
  localparam logic [9:0] B_FIRST = 10'd32;
  localparam logic [9:0] B_CTX   = 10'd128;

  typedef struct packed {
    logic [1:0]     fmt;
    logic [1:0]     sf;
    logic           th;
    logic [LEN-1:0] map;
    logic [CW-1:0]  cnt;
  } exp_t;

  logic clk, rst_ni, valid_i, ready_o;
  logic retired_i, branch_i, branch_taken_i, exception_i, updiscon_i;
  logic first_qualified_i, privchange_i, context_change_i, enc_disabled_i, opmode_change_i;
  logic packet_valid_o, packet_ready_i, thaddr_o, resync_pend_o;
  logic [1:0] packet_format_o, packet_subformat_o;
  logic [LEN-1:0] branch_map_o;
  logic [CW-1:0]  branch_cnt_o;

  trdb_priority_pkt #(
    .BRANCH_MAP_LEN(LEN), .RESYNC_W(RW), .RESYNC_MAX(16'd40), .RESYNC_MODE(0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .retired_i(retired_i), .branch_i(branch_i), .branch_taken_i(branch_taken_i),
    .exception_i(exception_i), .updiscon_i(updiscon_i),
    .first_qualified_i(first_qualified_i), .privchange_i(privchange_i),
    .context_change_i(context_change_i), .enc_disabled_i(enc_disabled_i),
    .opmode_change_i(opmode_change_i), .packet_valid_o(packet_valid_o),
    .packet_ready_i(packet_ready_i), .packet_format_o(packet_format_o),
    .packet_subformat_o(packet_subformat_o), .thaddr_o(thaddr_o),
    .branch_map_o(branch_map_o), .branch_cnt_o(branch_cnt_o),
    .resync_pend_o(resync_pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sink_mode = 0;   // 0 random, 1 stall, 2 always ready
  bit mon_en = 1'b0;

  exp_t        expq[$];
  bit          bq[$];
  bit          m_lce, m_lcu;
  int unsigned m_rs;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: branches kept as an ordered list, rules applied in priority order
  task automatic model_beat(input logic [9:0] f, output bit emit, output exp_t e);
    bit pend;
    int n;
    pend = (m_rs > RMAX);
    if (f[0] && f[1]) bq.push_back(f[2]);
    n = bq.size();
    e = '0;
    emit = 1'b1;
    if (m_lce) begin
      e.fmt = 2'd3; e.sf = 2'd1; e.th = 1'b1;
    end else if (f[5] || f[6] || (pend && n == 0)) begin
      e.fmt = 2'd3; e.sf = 2'd0;
    end else if (f[7]) begin
      e.fmt = 2'd3; e.sf = 2'd2;
    end else if (f[8] || f[9]) begin
      e.fmt = 2'd3; e.sf = 2'd3;
    end else if (m_lcu || pend) begin
      e.fmt = (n == 0) ? 2'd2 : 2'd1;
    end else if (n == LEN) begin
      e.fmt = 2'd1;
    end else begin
      emit = 1'b0;
    end
    if (emit && e.fmt != 2'd2) begin
      e.cnt = CW'(n);
      for (int i = 0; i < n; i++) e.map[i] = bq[i];
    end
    if (emit) bq.delete();
    m_lce = f[3];
    m_lcu = f[4];
    if (emit && e.fmt == 2'd3) m_rs = 0;
    else if (f[0] && m_rs < 65535) m_rs++;
  endtask

  // Issue one beat (called at posedge+1), wait bounded for acceptance
  task automatic beat(input logic [9:0] f);
    bit emit, got;
    exp_t e;
    got = 1'b0;
    {opmode_change_i, enc_disabled_i, context_change_i, privchange_i, first_qualified_i,
     updiscon_i, exception_i, branch_taken_i, branch_i, retired_i} = f;
    valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", ready_o, 1);
      valid_i = 1'b0;
      return;
    end
    model_beat(f, emit, e);
    @(posedge clk);
    if (emit) expq.push_back(e);
    #1;
    valid_i = 1'b0;
    chk("resync_pend", resync_pend_o, (m_rs > RMAX));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    expq.delete();
    bq.delete();
    m_lce = 1'b0;
    m_lcu = 1'b0;
    m_rs  = 0;
    #1;
    rst_ni = 1'b1;
  endtask

  // Emitter side ready
  initial begin
    packet_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0:       packet_ready_i = ($urandom_range(0, 3) != 0);
        1:       packet_ready_i = 1'b0;
        default: packet_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: compares presented packets against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni && mon_en) begin
        chk("pkt_valid", packet_valid_o, (expq.size() != 0));
        chk("ready", ready_o, (expq.size() == 0) || packet_ready_i);
        if (packet_valid_o && expq.size() != 0) begin
          chk("format", packet_format_o, expq[0].fmt);
          chk("subformat", packet_subformat_o, expq[0].sf);
          chk("thaddr", thaddr_o, expq[0].th);
          chk("branch_map", branch_map_o, expq[0].map);
          chk("branch_cnt", branch_cnt_o, expq[0].cnt);
          if (packet_ready_i) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [9:0] f;
    bit done;
    rst_ni = 1'b0;
    {valid_i, retired_i, branch_i, branch_taken_i, exception_i, updiscon_i} = '0;
    {first_qualified_i, privchange_i, context_change_i, enc_disabled_i, opmode_change_i} = '0;
    m_lce = 1'b0; m_lcu = 1'b0; m_rs = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("rst_valid", packet_valid_o, 0);
    chk("rst_cnt", branch_cnt_o, 0);
    chk("rst_pend", resync_pend_o, 0);
    chk("rst_ready", ready_o, 1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Start packet, full branch map, exception trap, updiscon with and without branches
    beat(B_FIRST);
    for (int i = 0; i < LEN; i++) beat(B_RET | B_BR | (((i % 2) == 0) ? B_TK : 10'd0));
    beat(B_RET);
    beat(B_RET | B_EXC);
    beat(B_RET);
    beat(B_RET | B_BR | B_TK);
    beat(B_RET | B_BR);
    beat(B_RET | B_BR | B_TK | B_UPD);
    beat(B_RET);
    beat(B_RET | B_UPD);
    beat(B_RET);
    beat(B_RET | B_EXC | B_UPD);
    beat(B_RET);
    beat(B_RET);

    // Resync threshold crossing on plain retires
    beat(B_RET | B_FIRST);
    for (int i = 0; i < RMAX + 2; i++) beat(B_RET);

    // Backpressure hold, release, then reset while holding
    sink_mode = 1;
    beat(B_RET | B_CTX);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("bp_ready", ready_o, 0);
    end
    sink_mode = 2;
    idle(3);
    sink_mode = 1;
    beat(B_RET | B_FIRST);
    idle(3);
    do_reset();
    chk("rst_mid_hold", packet_valid_o, 0);
    sink_mode = 0;

    // Randomized beats
    for (int n = 0; n < 700; n++) begin
      f = '0;
      f[0] = ($urandom_range(0, 3) != 0);
      f[1] = ($urandom_range(0, 1) != 0);
      f[2] = ($urandom_range(0, 1) != 0);
      f[3] = ($urandom_range(0, 15) == 0);
      f[4] = ($urandom_range(0, 9) == 0);
      f[5] = ($urandom_range(0, 39) == 0);
      f[6] = ($urandom_range(0, 39) == 0);
      f[7] = ($urandom_range(0, 29) == 0);
      f[8] = ($urandom_range(0, 39) == 0);
      f[9] = ($urandom_range(0, 39) == 0);
      beat(f);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    sink_mode = 2;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      idle(1);
      done = (expq.size() == 0);
    end
    chk("drain", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trdb_priority_pkt.md
Name: trdb_priority_pkt

Overview:
- Parametrised successor to the trace-encoder priority unit.
- Owns the state the previous unit took from outside: the last-cycle (lc) exception/updiscon flags, the branch map, and the resync counter.
- Decides per accepted retirement beat whether to emit a packet, and of which format/subformat.
- Sits between the instruction-qualification stage and the packet emitter; result is held in a one-entry output register with a valid/ready handshake.

Parameters:
- BRANCH_MAP_LEN, 31, capacity of the branch map in branches (1..31).
- RESYNC_W, 16, width of the resync counter.
- RESYNC_MAX, 16'd1024, resync threshold; a resync is pending when the counter is > RESYNC_MAX.
- RESYNC_MODE, 0: counter counts retired beats. 1: counter counts emitted packets.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  1  upstream beat valid; upstream holds all inputs while ready_o=0
- ready_o  out  1  beat accepted when valid_i&&ready_o
- retired_i  in  1  instruction retired this beat
- branch_i  in  1  retired instruction is a conditional branch
- branch_taken_i  in  1  branch outcome (1 = taken)
- exception_i  in  1  exception/interrupt on this beat
- updiscon_i  in  1  uninferable discontinuity on this beat
- first_qualified_i  in  1  first qualified instruction after trace start
- privchange_i  in  1  privilege change
- context_change_i  in  1  context change
- enc_disabled_i  in  1  encoder being disabled
- opmode_change_i  in  1  operating mode change
- packet_valid_o  out  1  output register holds a packet
- packet_ready_i  in  1  emitter consumes the packet
- packet_format_o  out  2  1/2/3
- packet_subformat_o  out  2  F3 subformat: 0 start, 1 trap, 2 context, 3 support
- thaddr_o  out  1  trap-address flag (F3 SF1 only)
- branch_map_o  out  BRANCH_MAP_LEN  bit k = outcome of branch k, oldest at bit 0
- branch_cnt_o  out  $clog2(BRANCH_MAP_LEN+1)  valid branches in branch_map_o
- resync_pend_o  out  1  resync counter > RESYNC_MAX (status)

Behaviour:
- Reset (rst_ni=0 at posedge): all registers, all outputs, map, count, resync counter, lc flags -> 0. ready_o is 1 from the first cycle after reset release. Reset mid-packet discards the held packet.
- ready_o = !packet_valid_o || packet_ready_i (combinational).
- Non-accepted cycles change no state except clearing packet_valid_o on consumption.
- Branch accumulation on accept:
  - If retired_i&&branch_i, write branch_taken_i at index cnt; cnt+1 gives the updated map/cnt.
  - Packet decision uses the updated map/cnt.
- Priority (first match wins; packet registered at the next posedge, 1-cycle latency):
  - P1 lc_exception_q -> F3 SF1, thaddr=1.
  - P2 first_qualified_i || privchange_i || (resync_pend && cnt==0) -> F3 SF0.
  - P3 context_change_i -> F3 SF2.
  - P4 enc_disabled_i || opmode_change_i -> F3 SF3.
  - P5 lc_updiscon_q || resync_pend -> F2 if cnt==0, else F1 with map.
  - P6 cnt==BRANCH_MAP_LEN -> F1 with full map.
  - Otherwise no packet; packet_valid_o is cleared if it was consumed.
- Outputs are zero for non-applicable fields (thaddr=0 except P1; subformat=0 for F1/F2).
- branch_map_o/branch_cnt_o carry the updated map on F1/F3 and 0 on F2.
- On any emitted packet, the stored map and cnt clear to 0.
- lc flags: lc_exception_q<=exception_i and lc_updiscon_q<=updiscon_i on every accept. Unchanged when not accepting.
- Resync counter:
  - Cleared on any F3 emission (clear wins over increment).
  - Otherwise increments on accepted beats with retired_i (mode 0), or on each emitted packet (mode 1).
  - Saturates at all-ones.
  - resync_pend is registered: evaluated from the counter value before the current beat.
- Simultaneous exception_i and updiscon_i: both lc flags set; next beat P1 wins, and lc_updiscon is consumed (cleared by that accept).
- Backpressure: while packet_valid_o&&!packet_ready_i, outputs are stable and ready_o=0.

Test Plan:
- Reset, then beat with first_qualified_i=1 -> next cycle packet_valid_o=1, F3 SF0, cnt=0, resync counter 0.
- 31 accepted branch beats (taken pattern alternating 1,0,…) -> F1 after the 31st, branch_map_o=31'h55555555 masked to 31 bits, cnt=31; next map empty.
- Exception beat, then a plain retire beat -> second beat yields F3 SF1 thaddr=1; exception beat alone emits nothing.
- Updiscon with 3 prior branches (T,N,T) -> next beat F1 cnt=3 map=3'b101; repeat with 0 branches -> F2 cnt=0.
- RESYNC_MAX=4, mode 0, 6 plain retires, no branches -> resync_pend_o=1 after the 5th retire; the 6th beat emits F3 SF0 and the counter returns to 0.
- Hold packet_ready_i=0 with a pending packet -> ready_o=0, outputs frozen for 5 cycles; assert ready -> consumed; a reset pulse mid-hold -> packet_valid_o=0 next cycle.
